// File: rtl/pmod_link_master.sv
// Host-side driver for the 8-out/4-in PMOD link: drives a stimulus byte, waits for it
// to settle, then captures the de-inverted, synchronized response nibble once stable.
module pmod_link_master #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] pin_out,
  input  logic [3:0] pin_in_n,
  output logic [3:0] rsp_data,
  output logic       rsp_timeout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       busy
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] STABLE_MAX   = BW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, WATCH, RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    sync1_reg, sync2_reg;
  logic [3:0]    s;
  logic [7:0]    pin_out_reg, pin_out_next;
  logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
  logic [BW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [TW-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic [3:0]    prev_reg, prev_next;
  logic [3:0]    rsp_data_reg, rsp_data_next;
  logic          rsp_timeout_reg, rsp_timeout_next;

  // Synchronizer resets to all-ones so an idle link reads as a zero response.
  assign s = ~sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      sync1_reg       <= 4'hF;
      sync2_reg       <= 4'hF;
      pin_out_reg     <= 8'h00;
      settle_cnt_reg  <= '0;
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      prev_reg        <= 4'h0;
      rsp_data_reg    <= 4'h0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sync1_reg       <= pin_in_n;
      sync2_reg       <= sync1_reg;
      pin_out_reg     <= pin_out_next;
      settle_cnt_reg  <= settle_cnt_next;
      stable_cnt_reg  <= stable_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      prev_reg        <= prev_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pin_out_next     = pin_out_reg;
    settle_cnt_next  = settle_cnt_reg;
    stable_cnt_next  = stable_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    prev_next        = prev_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_timeout_next = rsp_timeout_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          pin_out_next    = cmd_data;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
          prev_next        = s;
          stable_cnt_next  = BW'(1);
          timeout_cnt_next = '0;
          state_next       = WATCH;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      WATCH: begin
        timeout_cnt_next = timeout_cnt_reg + 1'b1;
        if (s == prev_reg) begin
          if (stable_cnt_reg != STABLE_MAX) stable_cnt_next = stable_cnt_reg + 1'b1;
        end else begin
          stable_cnt_next = BW'(1);
          prev_next       = s;
        end
        // Stable capture is tested first so it wins when both limits hit together.
        if (stable_cnt_reg == STABLE_MAX) begin
          rsp_data_next    = s;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
          rsp_data_next    = s;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready   = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign rsp_valid   = (state_reg == RESP);
  assign pin_out     = pin_out_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_pmod_link_master.sv
// Directed bench for pmod_link_master: latency, glitch restart, timeout capture,
// back-pressure, stable/timeout coincidence and asynchronous reset.
module tb_pmod_link_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] pin_out;
  logic [3:0] pin_in_n = 4'hF;
  logic [3:0] rsp_data;
  logic       rsp_timeout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       busy;

  // Second instance with a short timeout so stable and timeout limits coincide.
  logic [7:0] cmd_data2 = 8'h00;
  logic       cmd_valid2 = 1'b0;
  logic       cmd_ready2;
  logic [7:0] pin_out2;
  logic [3:0] pin_in_n2 = 4'hF;
  logic [3:0] rsp_data2;
  logic       rsp_timeout2;
  logic       rsp_valid2;
  logic       rsp_ready2 = 1'b1;
  logic       busy2;

  int total = 0;
  int bad = 0;

  // Independent two-flop model of the input path; m2_used is the stage-2 value an edge consumed.
  logic [3:0] m1, m2, m2_used;
  always @(posedge clk) begin
    m1      <= pin_in_n;
    m2      <= m1;
    m2_used <= m2;
  end

  always #5 clk = ~clk;

  pmod_link_master dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .pin_out(pin_out), .pin_in_n(pin_in_n), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy)
  );

  pmod_link_master #(.SETTLE_CYCLES(16), .STABLE_CYCLES(3), .TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .cmd_data(cmd_data2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .pin_out(pin_out2), .pin_in_n(pin_in_n2), .rsp_data(rsp_data2), .rsp_timeout(rsp_timeout2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .busy(busy2)
  );

  // Issue one command; returns at the falling edge after the acceptance edge E0.
  task automatic send_cmd(input logic [7:0] d);
    @(negedge clk);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts edges after E0 until rsp_valid is seen; lat = -1 if it never rises.
  task automatic wait_rsp(input int start, output int lat);
    int n;
    n   = start;
    lat = -1;
    while (n < start + 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (pin_out !== 8'h00) begin bad++; $display("FAIL reset_pin_out got=%h want=00", pin_out); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (rsp_data !== 4'h0 || rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL reset_rsp got=%h/%b want=0/0", rsp_data, rsp_timeout);
    end
    rst = 1'b0;
    $display("txn reset released");
  endtask

  task automatic test_basic;
    int lat;
    pin_in_n  = 4'b1010;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    send_cmd(8'hA5);
    total++; if (pin_out !== 8'hA5) begin bad++; $display("FAIL basic_pin_out got=%h want=a5", pin_out); end
    total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL basic_busy got=%b/%b want=1/0", busy, cmd_ready);
    end
    wait_rsp(0, lat);
    total++; if (lat != 19) begin bad++; $display("FAIL basic_latency got=%0d want=19", lat); end
    total++; if (rsp_data !== 4'h5 || rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL basic_rsp got=%h/%b want=5/0", rsp_data, rsp_timeout);
    end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL basic_one_cycle got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    $display("txn basic cmd=a5 lat=%0d rsp=%h to=%b", lat, rsp_data, rsp_timeout);
  endtask

  task automatic test_glitch;
    int lat;
    pin_in_n = 4'hC;
    repeat (4) @(negedge clk);
    send_cmd(8'h3C);
    repeat (14) @(negedge clk);
    pin_in_n = 4'h8;
    @(negedge clk);
    pin_in_n = 4'hC;
    wait_rsp(15, lat);
    total++; if (lat != 21) begin bad++; $display("FAIL glitch_latency got=%0d want=21", lat); end
    total++; if (rsp_data !== 4'h3 || rsp_timeout !== 1'b0) begin
      bad++; $display("FAIL glitch_rsp got=%h/%b want=3/0", rsp_data, rsp_timeout);
    end
    @(negedge clk);
    $display("txn glitch cmd=3c lat=%0d rsp=%h", lat, rsp_data);
  endtask

  task automatic test_timeout;
    int n;
    int lat;
    pin_in_n = 4'h6;
    send_cmd(8'hC3);
    n   = 0;
    lat = -1;
    while (n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
      pin_in_n = ~pin_in_n;
    end
    total++; if (lat != 272) begin bad++; $display("FAIL timeout_latency got=%0d want=272", lat); end
    total++; if (rsp_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b want=1", rsp_timeout); end
    total++; if (rsp_data !== ~m2_used) begin
      bad++; $display("FAIL timeout_data got=%h want=%h", rsp_data, ~m2_used);
    end
    @(negedge clk);
    $display("txn timeout cmd=c3 lat=%0d rsp=%h to=%b", lat, rsp_data, rsp_timeout);
  endtask

  task automatic test_backpressure;
    int lat;
    int errs;
    pin_in_n  = 4'h1;
    rsp_ready = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(8'h5A);
    wait_rsp(0, lat);
    total++; if (lat != 19 || rsp_data !== 4'hE) begin
      bad++; $display("FAIL bp_first got lat=%0d rsp=%h want 19/e", lat, rsp_data);
    end
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      cmd_valid = (i % 7 == 0);
      cmd_data  = 8'hFF;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 4'hE || rsp_timeout !== 1'b0 ||
          pin_out !== 8'h5A || cmd_ready !== 1'b0) errs++;
    end
    cmd_valid = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", errs); end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || pin_out !== 8'h5A) begin
      bad++; $display("FAIL bp_release got ready=%b valid=%b pin=%h want 1/0/5a", cmd_ready, rsp_valid, pin_out);
    end
    $display("txn backpressure cmd=5a held=50 rsp=%h", rsp_data);
  endtask

  task automatic test_coincide;
    int n;
    int lat;
    pin_in_n2 = 4'hF;
    repeat (4) @(negedge clk);
    cmd_data2  = 8'h42;
    cmd_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid2 = 1'b0;
    repeat (14) @(negedge clk);
    pin_in_n2 = 4'h2;
    n   = 14;
    lat = -1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid2) begin
        lat = n;
        break;
      end
    end
    total++; if (lat != 20) begin bad++; $display("FAIL coincide_latency got=%0d want=20", lat); end
    total++; if (rsp_timeout2 !== 1'b0 || rsp_data2 !== 4'hD) begin
      bad++; $display("FAIL coincide_rsp got=%h/%b want=d/0", rsp_data2, rsp_timeout2);
    end
    @(negedge clk);
    $display("txn coincide cmd=42 lat=%0d rsp=%h to=%b", lat, rsp_data2, rsp_timeout2);
  endtask

  task automatic test_async_reset;
    int lat;
    int seen;
    pin_in_n  = 4'hA;
    rsp_ready = 1'b1;
    send_cmd(8'h77);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (pin_out !== 8'h00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL arst_settle got pin=%h valid=%b ready=%b busy=%b want 00/0/1/0",
                      pin_out, rsp_valid, cmd_ready, busy);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL arst_settle_stale got=%0d want=0", seen); end

    rsp_ready = 1'b0;
    send_cmd(8'h99);
    wait_rsp(0, lat);
    total++; if (lat != 19 || rsp_data !== 4'h5) begin
      bad++; $display("FAIL arst_resp_pre got lat=%0d rsp=%h want 19/5", lat, rsp_data);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (pin_out !== 8'h00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== 4'h0) begin
      bad++; $display("FAIL arst_resp got pin=%h valid=%b ready=%b rsp=%h want 00/0/1/0",
                      pin_out, rsp_valid, cmd_ready, rsp_data);
    end
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL arst_resp_stale got=%0d want=0", seen); end
    $display("txn async_reset settle+resp");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_backpressure();
    test_coincide();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
